edge_detector_bank: RTL



---
 rtl/edge_detector_bank.sv | 93 +++++++++
 1 files changed

// File: rtl/edge_detector_bank.sv
// Multi-channel synchronise / debounce / edge-detect bank with one-cycle strobes and sticky event flags.
// Define EDGE_DETECTOR_DEBOUNCE_EN to include the per-channel debounce counter; otherwise level follows the synchroniser.
module edge_detector_bank #(
   parameter int CHANNELS        = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CHANNELS-1:0]   data,
   input  logic [2*CHANNELS-1:0] select_edge,
   input  logic [CHANNELS-1:0]   event_clear,
   output logic [CHANNELS-1:0]   level,
   output logic [CHANNELS-1:0]   pulso,
   output logic [CHANNELS-1:0]   event_pending
);

   if (CHANNELS < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
      $error("edge_detector_bank: illegal parameter combination");
   end

   // Strobe value for a level change from old_level to new_level under the channel mode.
   function automatic logic edge_strobe(input logic [1:0] mode, input logic new_level,
                                        input logic old_level);
      case (mode)
         2'b00:   return new_level & ~old_level;
         2'b01:   return ~new_level & old_level;
         2'b10:   return new_level ^ old_level;
         default: return 1'b0;
      endcase
   endfunction

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync;
      logic                   s;
      logic                   load;
      logic                   level_r;
      logic                   pulso_r;
      logic                   pending_r;
      logic                   strobe;

      assign s = sync[SYNC_STAGES-1];

      always_ff @(posedge clk) begin
         if (rst) begin
            sync <= '0;
         end else begin
            sync <= {sync[SYNC_STAGES-2:0], data[i]};
         end
      end

`ifdef EDGE_DETECTOR_DEBOUNCE_EN
      localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
      logic [CNT_W-1:0] cnt;

      // Any cycle where s agrees with the accepted level restarts the persistence count.
      assign load = (s != level_r) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

      always_ff @(posedge clk) begin
         if (rst) begin
            cnt <= '0;
         end else if (s == level_r || load) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
`else
      assign load = (s != level_r);
`endif

      assign strobe = load & edge_strobe(select_edge[2*i +: 2], s, level_r);

      always_ff @(posedge clk) begin
         if (rst) begin
            level_r   <= 1'b0;
            pulso_r   <= 1'b0;
            pending_r <= 1'b0;
         end else begin
            if (load) begin
               level_r <= s;
            end
            pulso_r   <= strobe;
            pending_r <= strobe | (pending_r & ~event_clear[i]);
         end
      end

      assign level[i]         = level_r;
      assign pulso[i]         = pulso_r;
      assign event_pending[i] = pending_r;
   end

endmodule
